spi_ram_slave: RTL and testbench

//  Parametrised SPI mode-0 slave fronting a DEPTH x DW register RAM. Decodes an 8-bit command,

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_ram_sp.sv | 22 ++
 rtl/spi_ram_slave.sv | 165 ++++++++++++++++
 tb/tb_spi_ram_slave.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared opcodes, FSM states and status-bit positions for the SPI RAM slave.
package spi_pkg;

    typedef enum logic [7:0] {
        CMD_WRITE = 8'h02,
        CMD_READ  = 8'h03,
        CMD_WRDI  = 8'h04,
        CMD_RDSR  = 8'h05,
        CMD_WREN  = 8'h06
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, RDATA, STATUS, IGNORE
    } state_e;

    localparam int STAT_WEL    = 0;
    localparam int STAT_WR_ERR = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_ram_sp.sv
// Single-port register RAM: synchronous write, asynchronous read, contents never reset.
module spi_ram_sp #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    localparam int DEPTH = 2**AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/spi_ram_slave.sv
// SPI mode-0 slave: command / address / burst-data decoder in front of a register RAM,
// with status register, write-enable latch and abort on SSB high.
module spi_ram_slave
    import spi_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic       SCK,
    input  logic       reset_n,
    input  logic       SSB,
    input  logic       MOSI,
    output logic       MISO,
    output logic       miso_oe,
    output logic       wr_pulse,
    output logic [7:0] status
);
    localparam int SW = max3(8, AW, DW);
    localparam int CW = $clog2(SW + 1);

    state_e        state, state_nx;
    logic [CW-1:0] bitcnt, bitcnt_nx;
    logic [SW-1:0] shreg, shreg_nx, sh_in;
    logic [AW-1:0] addr, addr_nx, ram_addr;
    logic          is_read, is_read_nx;
    logic          wel, wel_nx, wr_err, wr_err_nx;
    logic          we, wr_pulse_nx;
    logic [DW-1:0] rdata;
    logic [7:0]    st_clr;
    logic          frame_rst_n;

    // Per-frame state drops the moment SSB rises; persistent state only on reset_n.
    assign frame_rst_n = reset_n & ~SSB;
    assign sh_in       = {shreg[SW-2:0], MOSI};

    function automatic logic [SW-1:0] stat_word(input logic [7:0] s);
        logic [SW-1:0] r;
        r = '0;
        r[DW-1 -: 8] = s;
        return r;
    endfunction

    always_comb begin
        status = '0;
        status[STAT_WEL]    = wel;
        status[STAT_WR_ERR] = wr_err;
        st_clr = status;
        st_clr[STAT_WR_ERR] = 1'b0;
    end

    spi_ram_sp #(.DW(DW), .AW(AW)) u_ram (
        .clk   (SCK),
        .we    (we),
        .addr  (ram_addr),
        .wdata (sh_in[DW-1:0]),
        .rdata (rdata)
    );

    always_comb begin
        state_nx    = state;
        bitcnt_nx   = bitcnt + CW'(1);
        shreg_nx    = sh_in;
        addr_nx     = addr;
        is_read_nx  = is_read;
        wel_nx      = wel;
        wr_err_nx   = wr_err;
        we          = 1'b0;
        wr_pulse_nx = 1'b0;
        ram_addr    = addr;
        case (state)
            IDLE, CMD: begin
                // The edge that leaves IDLE already carries the first command bit.
                state_nx = CMD;
                if (bitcnt == CW'(7)) begin
                    bitcnt_nx = '0;
                    case (sh_in[7:0])
                        CMD_WREN:  begin wel_nx = 1'b1; state_nx = IGNORE; end
                        CMD_WRDI:  begin wel_nx = 1'b0; state_nx = IGNORE; end
                        CMD_WRITE: state_nx = ADDR;
                        CMD_READ:  begin is_read_nx = 1'b1; state_nx = ADDR; end
                        CMD_RDSR:  begin state_nx = STATUS; shreg_nx = stat_word(status); end
                        default:   state_nx = IGNORE;
                    endcase
                end
            end
            ADDR: begin
                if (bitcnt == CW'(AW - 1)) begin
                    bitcnt_nx = '0;
                    addr_nx   = sh_in[AW-1:0];
                    if (is_read) begin
                        ram_addr = sh_in[AW-1:0];
                        shreg_nx = SW'(rdata);
                        addr_nx  = sh_in[AW-1:0] + AW'(1);
                        state_nx = RDATA;
                    end else begin
                        state_nx = WDATA;
                    end
                end
            end
            WDATA: begin
                if (bitcnt == CW'(DW - 1)) begin
                    bitcnt_nx = '0;
                    addr_nx   = addr + AW'(1);
                    if (wel) begin
                        we          = 1'b1;
                        wr_pulse_nx = 1'b1;
                    end else begin
                        wr_err_nx = 1'b1;
                    end
                end
            end
            RDATA: begin
                if (bitcnt == CW'(DW - 1)) begin
                    bitcnt_nx = '0;
                    shreg_nx  = SW'(rdata);
                    addr_nx   = addr + AW'(1);
                end
            end
            STATUS: begin
                // Reload shows the post-clear value so the next byte reflects the read.
                if (bitcnt == CW'(7)) begin
                    bitcnt_nx = '0;
                    wr_err_nx = 1'b0;
                    shreg_nx  = stat_word(st_clr);
                end
            end
            default: begin
                bitcnt_nx = bitcnt;
                shreg_nx  = shreg;
            end
        endcase
    end

    always_ff @(posedge SCK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state   <= IDLE;
            bitcnt  <= '0;
            shreg   <= '0;
            is_read <= 1'b0;
        end else begin
            state   <= state_nx;
            bitcnt  <= bitcnt_nx;
            shreg   <= shreg_nx;
            is_read <= is_read_nx;
        end
    end

    always_ff @(posedge SCK or negedge reset_n) begin
        if (!reset_n) begin
            addr     <= '0;
            wel      <= 1'b0;
            wr_err   <= 1'b0;
            wr_pulse <= 1'b0;
        end else begin
            addr     <= addr_nx;
            wel      <= wel_nx;
            wr_err   <= wr_err_nx;
            wr_pulse <= wr_pulse_nx;
        end
    end

    assign miso_oe = (state == RDATA) || (state == STATUS);
    assign MISO    = miso_oe & shreg[DW-1];

endmodule

// File: tb/tb_spi_ram_slave.sv
// Self-checking bench for spi_ram_slave: SPI master tasks, memory/status model, byte scoreboard.
module tb_spi_ram_slave;
    import spi_pkg::*;

    logic       SCK = 1'b0, reset_n = 1'b0, SSB = 1'b1, MOSI = 1'b0;
    logic       MISO, miso_oe, wr_pulse;
    logic [7:0] status;

    int         n_chk = 0, n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem_m [256];
    logic       wel_m = 1'b0, err_m = 1'b0;
    logic [7:0] rx, e;
    logic       oe;

    spi_ram_slave #(.DW(8), .AW(8)) dut (
        .SCK(SCK), .reset_n(reset_n), .SSB(SSB), .MOSI(MOSI),
        .MISO(MISO), .miso_oe(miso_oe), .wr_pulse(wr_pulse), .status(status)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Master samples MISO while SCK is low, just before the rising edge.
    task automatic bits(input logic [7:0] tx, input int n, output logic [7:0] rxb, output logic oe_all);
        rxb = '0;
        oe_all = 1'b1;
        for (int i = 7; i > 7 - n; i--) begin
            MOSI = tx[i];
            #5;
            rxb[i] = MISO;
            oe_all = oe_all & miso_oe;
            SCK = 1'b1;
            #5;
            SCK = 1'b0;
        end
    endtask

    task automatic sel();
        SSB = 1'b0;
        #5;
    endtask

    task automatic desel();
        #5;
        SSB = 1'b1;
        #10;
    endtask

    task automatic wr_cmd(input logic [7:0] c);
        logic [7:0] r;
        logic o;
        sel();
        bits(c, 8, r, o);
        desel();
        if (c == CMD_WREN) wel_m = 1'b1;
        if (c == CMD_WRDI) wel_m = 1'b0;
        chk("status_after_cmd", status, {6'b0, err_m, wel_m});
    endtask

    task automatic write_burst(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
        logic [7:0] r, d;
        logic o;
        sel();
        bits(CMD_WRITE, 8, r, o);
        bits(a, 8, r, o);
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : d1;
            bits(d, 8, r, o);
            if (wel_m) mem_m[a + 8'(k)] = d;
            else       err_m = 1'b1;
            chk("wr_pulse", wr_pulse, wel_m);
        end
        desel();
        chk("status_after_wr", status, {6'b0, err_m, wel_m});
    endtask

    task automatic read_burst(input logic [7:0] a, input int n);
        logic [7:0] r, ex;
        logic o;
        sel();
        bits(CMD_READ, 8, r, o);
        bits(a, 8, r, o);
        for (int k = 0; k < n; k++) exp_q.push_back(mem_m[a + 8'(k)]);
        for (int k = 0; k < n; k++) begin
            bits(8'h00, 8, r, o);
            ex = exp_q.pop_front();
            chk("rd_data", r, ex);
            chk("rd_oe", o, 1);
        end
        desel();
    endtask

    task automatic rdsr(input int n);
        logic [7:0] r, ex;
        logic o;
        sel();
        bits(CMD_RDSR, 8, r, o);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({6'b0, err_m, wel_m});
            err_m = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            bits(8'h00, 8, r, o);
            ex = exp_q.pop_front();
            chk("rdsr_data", r, ex);
            chk("rdsr_oe", o, 1);
        end
        desel();
        chk("status_after_rdsr", status, {6'b0, err_m, wel_m});
    endtask

    initial begin
        #20;
        chk("rst_miso", MISO, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_status", status, 0);
        reset_n = 1'b1;
        #10;

        // Known content at 0x20 so the protected write below is observable.
        wr_cmd(CMD_WREN);
        write_burst(8'h20, 8'h5A, 8'h00, 1);

        wr_cmd(CMD_WREN);
        write_burst(8'h10, 8'hA5, 8'h3C, 2);
        read_burst(8'h10, 2);

        wr_cmd(CMD_WRDI);
        write_burst(8'h20, 8'hFF, 8'h00, 1);
        read_burst(8'h20, 1);
        rdsr(2);

        wr_cmd(CMD_WREN);
        write_burst(8'hFF, 8'h11, 8'h22, 2);
        read_burst(8'hFF, 2);

        // Abort a write after five data bits.
        sel();
        bits(CMD_WRITE, 8, rx, oe);
        bits(8'h10, 8, rx, oe);
        bits(8'h77, 5, rx, oe);
        SSB = 1'b1;
        #1;
        chk("abort_wr_pulse", wr_pulse, 0);
        chk("abort_oe", miso_oe, 0);
        #10;
        rdsr(1);
        read_burst(8'h10, 1);

        // Async reset in the middle of a read data phase.
        sel();
        bits(CMD_READ, 8, rx, oe);
        bits(8'h10, 8, rx, oe);
        bits(8'h00, 3, rx, oe);
        chk("mid_read_oe", miso_oe, 1);
        reset_n = 1'b0;
        wel_m = 1'b0;
        err_m = 1'b0;
        #1;
        chk("rst_mid_miso", MISO, 0);
        chk("rst_mid_oe", miso_oe, 0);
        chk("rst_mid_status", status, 0);
        SSB = 1'b1;
        #5;
        reset_n = 1'b1;
        #10;
        read_burst(8'h10, 2);

        sel();
        bits(8'hAB, 8, rx, oe);
        for (int k = 0; k < 2; k++) begin
            bits(8'hFF, 8, rx, oe);
            chk("unk_miso", rx, 0);
            chk("unk_oe_any", oe, 0);
        end
        desel();
        rdsr(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
